// File: rtl/exc_if.sv
// Bundles the exception controller's core-side request inputs and its status outputs.
// The controller takes the slave modport; the core/testbench drives through master.
interface exc_if #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 64
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] Irq;
  logic [N_IRQ-1:0] IrqMask;
  logic             NotAnInstr;
  logic             ERet;
  logic [PC_W-1:0]  PcIn;
  logic             ExcTaken;
  logic             InExc;
  logic [3:0]       EStatus;
  logic [ID_W-1:0]  IrqId;
  logic [PC_W-1:0]  ELR;
  logic [N_IRQ-1:0] IrqAck;

  modport master (
    output Irq, IrqMask, NotAnInstr, ERet, PcIn,
    input  ExcTaken, InExc, EStatus, IrqId, ELR, IrqAck
  );

  modport slave (
    input  Irq, IrqMask, NotAnInstr, ERet, PcIn,
    output ExcTaken, InExc, EStatus, IrqId, ELR, IrqAck
  );
endinterface

// File: rtl/exception_ctrl.sv
// LEGv8 exception/interrupt controller: RUN -> TAKE -> HANDLER -> RUN, all outputs registered.
// Optional macro EXC_CTRL_IRQ_EDGE_EN switches IRQ requests from level to latched rising edges.
module exception_ctrl #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 64
) (
  input logic  clk,
  input logic  reset,
  exc_if.slave bus
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             exc_taken_q, exc_taken_d;
  logic             in_exc_q, in_exc_d;
  logic [3:0]       estatus_q, estatus_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [PC_W-1:0]  elr_q, elr_d;
  logic [N_IRQ-1:0] irq_ack_q, irq_ack_d;

  logic [N_IRQ-1:0] req_s;
  logic [N_IRQ-1:0] cand_s;
  logic [N_IRQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_id_s;
  logic             grant_vld_s;

`ifdef EXC_CTRL_IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q, pending_d;

  // Edges latch into pending; an ack clears its bit unless a new edge arrives the same cycle
  assign pending_d = (pending_q & ~irq_ack_d) | (bus.Irq & ~irq_q);
  assign req_s     = pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= bus.Irq;
      pending_q <= pending_d;
    end
  end
`else
  assign req_s = bus.Irq;
`endif

  // Lowest-index unmasked request wins; the mask acts combinationally
  assign cand_s  = req_s & ~bus.IrqMask;
  assign grant_s = cand_s & (~cand_s + {{(N_IRQ-1){1'b0}}, 1'b1});

  always_comb begin
    grant_id_s  = '0;
    grant_vld_s = |cand_s;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      grant_id_s = cand_s[k] ? ID_W'(k) : grant_id_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    exc_taken_d = 1'b0;
    irq_ack_d   = '0;
    in_exc_d    = in_exc_q;
    estatus_d   = estatus_q;
    irq_id_d    = irq_id_q;
    elr_d       = elr_q;
    case (state_q)
      ST_RUN: begin
        if (bus.NotAnInstr) begin
          state_d     = ST_TAKE;
          exc_taken_d = 1'b1;
          in_exc_d    = 1'b1;
          estatus_d   = 4'b0010;
          irq_id_d    = '0;
          elr_d       = bus.PcIn;
        end else if (grant_vld_s) begin
          state_d     = ST_TAKE;
          exc_taken_d = 1'b1;
          in_exc_d    = 1'b1;
          estatus_d   = 4'b0001;
          irq_id_d    = grant_id_s;
          irq_ack_d   = grant_s;
          elr_d       = bus.PcIn;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TAKE: begin
        state_d  = ST_HANDLER;
        in_exc_d = 1'b1;
      end
      ST_HANDLER: begin
        // No nesting: only ERET leaves; faults and IRQs wait until back in RUN
        if (bus.ERet) begin
          state_d   = ST_RUN;
          in_exc_d  = 1'b0;
          estatus_d = 4'b0000;
          irq_id_d  = '0;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: begin
        state_d   = ST_RUN;
        in_exc_d  = 1'b0;
        estatus_d = 4'b0000;
        irq_id_d  = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      exc_taken_q <= 1'b0;
      in_exc_q    <= 1'b0;
      estatus_q   <= 4'b0000;
      irq_id_q    <= '0;
      elr_q       <= '0;
      irq_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      exc_taken_q <= exc_taken_d;
      in_exc_q    <= in_exc_d;
      estatus_q   <= estatus_d;
      irq_id_q    <= irq_id_d;
      elr_q       <= elr_d;
      irq_ack_q   <= irq_ack_d;
    end
  end

  assign bus.ExcTaken = exc_taken_q;
  assign bus.InExc    = in_exc_q;
  assign bus.EStatus  = estatus_q;
  assign bus.IrqId    = irq_id_q;
  assign bus.ELR      = elr_q;
  assign bus.IrqAck   = irq_ack_q;
endmodule
